// File: rtl/key_conditioner_pkg.sv
// Shared constants for the calculator front-end key conditioner.
package calc_pkg;

  // Per-button debounce FSM encoding
  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // Active-low key codes understood by the calculator
  localparam logic [1:0] KEY_IDLE = 2'b11;
  localparam logic [1:0] KEY1     = 2'b10;
  localparam logic [1:0] KEY2     = 2'b01;

  // Depth of every input synchroniser chain
  localparam int unsigned SYNC_STAGES = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_conditioner_debounce_fsm.sv
// One pushbutton: 2-flop synchroniser, saturating counter, 4-state debounce FSM.
// Emits a registered one-cycle qualify pulse per accepted press and the
// debounced level (active-low). With KEY_AUTOREPEAT_EN defined, a held button
// also emits repeat qualify pulses.
module debounce_fsm
  import calc_pkg::*;
#(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_raw_i,
  output logic qualify_o,
  output logic level_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LIM  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RP_LIM  = CNT_W'(REPEAT_PERIOD);
  logic rep_q, rep_d;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   qual_q, qual_d;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  // Synchroniser chain, idles at released (1)
  always_ff @(posedge clk_i) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw_i};
  end

  // Debounce next-state logic. The sample that triggers leaving a stable
  // state counts as the first of the DEBOUNCE_CYCLES, so entry loads 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qual_d  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      RELEASED: begin
        cnt_d = '0;
        if (!sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (sync) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_inc == DB_LIM) begin
          state_d = PRESSED;
          cnt_d   = '0;
          qual_d  = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          rep_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
`ifdef KEY_AUTOREPEAT_EN
          if (cnt_inc == (rep_q ? RP_LIM : RD_LIM)) begin
            qual_d = 1'b1;
            cnt_d  = '0;
            rep_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      RELEASE_WAIT: begin
        if (!sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
          rep_d   = 1'b0;
`endif
        end else if (cnt_inc == DB_LIM) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and qualify registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      qual_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qual_q  <= qual_d;
`ifdef KEY_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign qualify_o = qual_q;
  assign level_o   = !((state_q == PRESSED) || (state_q == RELEASE_WAIT));

endmodule

// File: rtl/key_conditioner.sv
// Calculator input stage: synchronises operand / ALU-op switches, debounces the
// two record buttons and arbitrates their presses onto the active-low `key`
// strobe (2'b10 = operand 1, 2'b01 = operand 2, 2'b11 = idle, never 2'b00).
// Optional auto-repeat of held buttons: define KEY_AUTOREPEAT_EN.
module key_conditioner
  import calc_pkg::*;
#(
  parameter int unsigned ENTER_SW        = 4,
  parameter int unsigned ALU_SW          = 4,
  parameter int unsigned RECORD          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RECORD-1:0]   key_raw,
  input  logic [ENTER_SW-1:0] sw_raw,
  input  logic [ALU_SW-1:0]   arif_raw,
  output logic [RECORD-1:0]   key,
  output logic [RECORD-1:0]   key_level,
  output logic [ENTER_SW-1:0] in_number,
  output logic [ALU_SW-1:0]   arif
);

  localparam int unsigned CNT_W =
    $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [SYNC_STAGES-1:0][ENTER_SW-1:0] sw_q;
  logic [SYNC_STAGES-1:0][ALU_SW-1:0]   arif_q;
  logic [1:0] qual, lvl;
  logic [1:0] key_q, key_d, lvl_q;
  logic       pend_q, pend_d;

  for (genvar b = 0; b < 2; b++) begin : g_btn
    debounce_fsm #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_debounce (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .key_raw_i(key_raw[b]),
      .qualify_o(qual[b]),
      .level_o  (lvl[b])
    );
  end

  // Switch synchronisers, cleared to 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_q   <= '0;
      arif_q <= '0;
    end else begin
      sw_q[0]   <= sw_raw;
      arif_q[0] <= arif_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sw_q[i]   <= sw_q[i-1];
        arif_q[i] <= arif_q[i-1];
      end
    end
  end

  // Strobe arbiter: button 0 wins a tie, button 1 is deferred one cycle
  always_comb begin
    key_d  = KEY_IDLE;
    pend_d = pend_q;
    if (qual[0]) begin
      key_d = KEY1;
      if (qual[1]) pend_d = 1'b1;
    end else if (pend_q) begin
      key_d  = KEY2;
      pend_d = qual[1];
    end else if (qual[1]) begin
      key_d = KEY2;
    end
  end

  // Registered strobe, pending flag and debounced level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q  <= KEY_IDLE;
      pend_q <= 1'b0;
      lvl_q  <= 2'b11;
    end else begin
      key_q  <= key_d;
      pend_q <= pend_d;
      lvl_q  <= lvl;
    end
  end

  assign key       = key_q;
  assign key_level = lvl_q;
  assign in_number = sw_q[SYNC_STAGES-1];
  assign arif      = arif_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3). Directed scenarios followed by random button/switch
// activity, all compared each cycle against a run-length/queue reference model.
module tb_key_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] key_raw;
  logic [3:0] sw_raw, arif_raw;
  logic [1:0] key, key_level;
  logic [3:0] in_number, arif;

  key_conditioner #(
    .ENTER_SW       (4),
    .ALU_SW         (4),
    .RECORD         (2),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_raw  (key_raw),
    .sw_raw   (sw_raw),
    .arif_raw (arif_raw),
    .key      (key),
    .key_level(key_level),
    .in_number(in_number),
    .arif     (arif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: debounced level flips after D consecutive synced samples
  // that disagree with it; presses (and repeats) queue strobes in button order.
  bit         m_s1[2], m_s2[2];
  bit         m_pr[2];
  int         m_run[2];
  int         m_t[2];
  int         strobe_q[$];
  logic [3:0] m_sw1, m_sw2, m_ar1, m_ar2;
  logic [1:0] exp_key, exp_lvl;

  task automatic model_edge();
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 1'b1; m_s2[b] = 1'b1; m_pr[b] = 1'b0; m_run[b] = 0; m_t[b] = 0;
      end
      strobe_q.delete();
      m_sw1 = '0; m_sw2 = '0; m_ar1 = '0; m_ar2 = '0;
      exp_key = 2'b11;
      exp_lvl = 2'b11;
    end else begin
      exp_key = 2'b11;
      if (strobe_q.size() > 0) exp_key = (strobe_q.pop_front() == 0) ? 2'b10 : 2'b01;
      exp_lvl = {~m_pr[1], ~m_pr[0]};
      for (int b = 0; b < 2; b++) begin
        bit pressed_sample;
        pressed_sample = !m_s2[b];
        if (pressed_sample != m_pr[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_pr[b]  = pressed_sample;
            m_run[b] = 0;
            m_t[b]   = 0;
            if (m_pr[b]) strobe_q.push_back(b);
          end
        end else begin
          if (m_pr[b] && m_run[b] > 0) begin
            m_t[b] = 0;
          end else if (m_pr[b]) begin
            m_t[b]++;
`ifdef KEY_AUTOREPEAT_EN
            if (m_t[b] == RD || (m_t[b] > RD && (m_t[b] - RD) % RP == 0))
              strobe_q.push_back(b);
`endif
          end
          m_run[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = key_raw[b];
      end
      m_sw2 = m_sw1; m_sw1 = sw_raw;
      m_ar2 = m_ar1; m_ar1 = arif_raw;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("key",        {30'd0, key},       {30'd0, exp_key});
    check_eq("key_level",  {30'd0, key_level}, {30'd0, exp_lvl});
    check_eq("in_number",  {28'd0, in_number}, {28'd0, m_sw2});
    check_eq("arif",       {28'd0, arif},      {28'd0, m_ar2});
    check_eq("key_not_00", {31'd0, (key == 2'b00)}, 32'd0);
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int hold[2];

  initial begin
    rst_n = 1'b0; key_raw = 2'b00; sw_raw = 4'h0; arif_raw = 4'h0;
    // Reset with both buttons held, then release reset
    steps(3);
    rst_n = 1'b1;
    steps(12);
    key_raw = 2'b11;
    steps(15);
    // Clean press on button 0
    key_raw[0] = 1'b0;
    steps(20);
    key_raw[0] = 1'b1;
    steps(15);
    // Bounce on button 1, then held
    foreach (hold[i]) hold[i] = 0;
    for (int i = 0; i < 5; i++) begin
      key_raw[1] = i[0];
      step();
    end
    key_raw[1] = 1'b0;
    steps(12);
    key_raw[1] = 1'b1;
    steps(15);
    // Simultaneous press
    key_raw = 2'b00;
    steps(12);
    key_raw = 2'b11;
    steps(15);
    // Switch synchronisation
    sw_raw = 4'hA; arif_raw = 4'h5;
    steps(4);
    // Long hold (auto-repeat when enabled)
    key_raw[0] = 1'b0;
    steps(30);
    key_raw[0] = 1'b1;
    steps(15);
    // Random activity including short bounces, long holds and mid-press resets
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 2; b++) begin
        if (hold[b] == 0) begin
          key_raw[b] = ~key_raw[b];
          hold[b] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 40))
                                                : int'($urandom_range(1, 7));
        end
        hold[b]--;
      end
      if ($urandom_range(0, 3) == 0) sw_raw   = 4'($urandom);
      if ($urandom_range(0, 3) == 0) arif_raw = 4'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1'b1;
    key_raw = 2'b11;
    steps(20);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
